cache_level_ctrl: RTL and testbench

CACHE_LEVEL_CTRL -- requirements
Module: cache_level_ctrl

---
 rtl/cache_config_pkg.sv | 32 +++
 rtl/cache_lru_age.sv | 69 ++++++
 rtl/cache_level_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_cache_level_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_config_pkg.sv
// rtl/cache_config_pkg.sv - shared controller state and line-metadata types for cache_level_ctrl
//
// Purpose : Types shared by the cache controller and its LRU helper.
//           Cache geometry is not fixed here; it stays as module parameters.
// Ports   : none (package).
//   state_t     - controller FSM states
//   line_meta_t - per-line valid/dirty bits
//   sat_inc     - 32-bit saturating increment used by the statistics counters

package cache_config;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_WRITEBACK,
      ST_REFILL,
      ST_RESPOND,
      ST_SNOOP_WB
   } state_t;

   typedef struct packed {
      logic valid;
      logic dirty;
   } line_meta_t;

   localparam int unsigned CNT_WIDTH = 32;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/cache_lru_age.sv
// rtl/cache_lru_age.sv - per-set age update and victim selection for cache_level_ctrl
//
// Purpose : Combinational helper operating on one set.
//           Ages form a permutation of 0..NUM_WAYS-1 (0 = MRU).
// Ports   :
//   ages      in  packed ages of every way in the set (way w at [w*AGE_W +: AGE_W])
//   valids    in  valid bit of every way in the set
//   hit_way   in  way being touched
//   ages_next out ages after touching hit_way
//   victim    out lowest-index invalid way, otherwise the oldest way

module cache_lru_age
   import cache_config::*;
#(
   parameter int NUM_WAYS = 4,
   parameter int AGE_W    = 2
) (
   input  logic [NUM_WAYS*AGE_W-1:0] ages,
   input  logic [NUM_WAYS-1:0]       valids,
   input  logic [AGE_W-1:0]          hit_way,
   output logic [NUM_WAYS*AGE_W-1:0] ages_next,
   output logic [AGE_W-1:0]          victim
);

   logic [AGE_W-1:0] old_age;
   logic [AGE_W-1:0] max_age;
   logic [AGE_W-1:0] a;
   logic             found;

   always_comb begin
      old_age   = '0;
      max_age   = '0;
      a         = '0;
      found     = 1'b0;
      victim    = '0;
      ages_next = ages;

      for (int w = 0; w < NUM_WAYS; w++) begin
         if (AGE_W'(w) == hit_way) old_age = ages[w*AGE_W +: AGE_W];
      end

      // Only ways younger than the touched one age by one, so the set
      // remains a permutation and no age can exceed NUM_WAYS-1.
      for (int w = 0; w < NUM_WAYS; w++) begin
         a = ages[w*AGE_W +: AGE_W];
         if (AGE_W'(w) == hit_way)
            ages_next[w*AGE_W +: AGE_W] = '0;
         else if (a < old_age)
            ages_next[w*AGE_W +: AGE_W] = a + 1'b1;
      end

      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!valids[w] && !found) begin
            victim = AGE_W'(w);
            found  = 1'b1;
         end
      end

      if (!found) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (ages[w*AGE_W +: AGE_W] >= max_age) begin
               max_age = ages[w*AGE_W +: AGE_W];
               victim  = AGE_W'(w);
            end
         end
      end
   end

endmodule

// File: rtl/cache_level_ctrl.sv
// rtl/cache_level_ctrl.sv - set-associative write-back cache level controller with snoop invalidation
//
// Purpose : Serves single-word upstream reads/writes from a write-back,
//           write-allocate cache with age-based LRU, fetching and evicting
//           whole lines over a simple req/ack memory port, and handling
//           invalidating snoops (dirty lines are written back first).
// Ports   :
//   clk, reset                      clock, asynchronous active-high reset
//   req_valid/req_ready             upstream request handshake
//   req_write/req_addr/req_wdata    request fields (byte address, one word)
//   resp_valid/resp_rdata           one-cycle response pulse with the word
//   mem_req/mem_write/mem_addr      line transaction to memory (held until mem_ack)
//   mem_wdata/mem_ack/mem_rdata     line write data, completion, line read data
//   snoop_valid/snoop_addr          invalidation request
//   snoop_done/snoop_hit            one-cycle completion pulse, line was present
//   hit_count/miss_count/wb_count   saturating statistics

module cache_level_ctrl
   import cache_config::*;
#(
   parameter int NUM_SETS   = 4,
   parameter int NUM_WAYS   = 4,
   parameter int LINE_WIDTH = 128,
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WORD_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [WORD_WIDTH-1:0] resp_rdata,
   output logic                  mem_req,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  snoop_valid,
   input  logic [ADDR_WIDTH-1:0] snoop_addr,
   output logic                  snoop_done,
   output logic                  snoop_hit,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count,
   output logic [31:0]           wb_count
);

   localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
   localparam int WAY_W  = $clog2(NUM_WAYS);
   localparam int WPL    = LINE_WIDTH / WORD_WIDTH;
   localparam int WB_W   = $clog2(WORD_WIDTH / 8);
   localparam int WSEL_W = (WPL > 1) ? $clog2(WPL) : 1;
   localparam int LN_W   = ADDR_WIDTH - OFF_W;

   state_t                state;
   line_meta_t            meta     [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0]      tag_mem  [NUM_SETS][NUM_WAYS];
   logic [LINE_WIDTH-1:0] data_mem [NUM_SETS][NUM_WAYS];
   logic [WAY_W-1:0]      age_mem  [NUM_SETS][NUM_WAYS];

   // Registered request: line address and word select only.
   logic                  r_write;
   logic [LN_W-1:0]       r_line;
   logic [WSEL_W-1:0]     r_wsel;
   logic [WORD_WIDTH-1:0] r_wdata;
   logic                  refilled;
   logic [WAY_W-1:0]      vic_way;
   logic [WAY_W-1:0]      snp_way;
   logic [IDX_W-1:0]      snp_idx;

   logic [IDX_W-1:0]      req_idx, snp_idx_c;
   logic [TAG_W-1:0]      req_tag, snp_tag_c;
   logic                  req_hit, snp_hit;
   logic [WAY_W-1:0]      req_hit_way, snp_hit_way;
   logic [NUM_WAYS*WAY_W-1:0] set_ages, ages_next;
   logic [NUM_WAYS-1:0]   set_valids;
   logic [WAY_W-1:0]      victim;
   line_meta_t            vic_meta;
   logic [WORD_WIDTH-1:0] hit_word;
   logic                  install_en, merge_en;
   logic                  unused_addr_bits;

   assign req_idx   = r_line[IDX_W-1:0];
   assign req_tag   = r_line[LN_W-1 -: TAG_W];
   assign snp_idx_c = snoop_addr[OFF_W +: IDX_W];
   assign snp_tag_c = snoop_addr[ADDR_WIDTH-1 -: TAG_W];
   assign unused_addr_bits = ^{snoop_addr[OFF_W-1:0], req_addr[WB_W-1:0]};

   assign req_ready = (state == ST_IDLE) && !snoop_valid;

   always_comb begin
      req_hit     = 1'b0;
      req_hit_way = '0;
      snp_hit     = 1'b0;
      snp_hit_way = '0;
      set_ages    = '0;
      set_valids  = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (meta[req_idx][w].valid && tag_mem[req_idx][w] == req_tag) begin
            req_hit     = 1'b1;
            req_hit_way = WAY_W'(w);
         end
         if (meta[snp_idx_c][w].valid && tag_mem[snp_idx_c][w] == snp_tag_c) begin
            snp_hit     = 1'b1;
            snp_hit_way = WAY_W'(w);
         end
         set_ages[w*WAY_W +: WAY_W] = age_mem[req_idx][w];
         set_valids[w]              = meta[req_idx][w].valid;
      end
   end

   cache_lru_age #(
      .NUM_WAYS (NUM_WAYS),
      .AGE_W    (WAY_W)
   ) u_lru (
      .ages      (set_ages),
      .valids    (set_valids),
      .hit_way   (req_hit_way),
      .ages_next (ages_next),
      .victim    (victim)
   );

   assign vic_meta   = meta[req_idx][victim];
   assign hit_word   = data_mem[req_idx][req_hit_way][r_wsel*WORD_WIDTH +: WORD_WIDTH];
   assign install_en = (state == ST_REFILL) && mem_ack;
   assign merge_en   = (state == ST_LOOKUP) && req_hit && r_write;

   // Line data and tags carry no reset; validity lives in meta.
   always_ff @(posedge clk) begin
      if (install_en) begin
         data_mem[req_idx][vic_way] <= mem_rdata;
         tag_mem[req_idx][vic_way]  <= req_tag;
      end else if (merge_en) begin
         data_mem[req_idx][req_hit_way][r_wsel*WORD_WIDTH +: WORD_WIDTH] <= r_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         r_write    <= 1'b0;
         r_line     <= '0;
         r_wsel     <= '0;
         r_wdata    <= '0;
         refilled   <= 1'b0;
         vic_way    <= '0;
         snp_way    <= '0;
         snp_idx    <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         mem_req    <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         snoop_done <= 1'b0;
         snoop_hit  <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               meta[s][w]    <= '0;
               age_mem[s][w] <= WAY_W'(w);
            end
         end
      end else begin
         resp_valid <= 1'b0;
         snoop_done <= 1'b0;
         snoop_hit  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (snoop_valid) begin
                  if (snp_hit && meta[snp_idx_c][snp_hit_way].dirty) begin
                     state     <= ST_SNOOP_WB;
                     snp_idx   <= snp_idx_c;
                     snp_way   <= snp_hit_way;
                     mem_req   <= 1'b1;
                     mem_write <= 1'b1;
                     mem_addr  <= {tag_mem[snp_idx_c][snp_hit_way], snp_idx_c, {OFF_W{1'b0}}};
                     mem_wdata <= data_mem[snp_idx_c][snp_hit_way];
                  end else begin
                     if (snp_hit) meta[snp_idx_c][snp_hit_way].valid <= 1'b0;
                     snoop_done <= 1'b1;
                     snoop_hit  <= snp_hit;
                  end
               end else if (req_valid) begin
                  state    <= ST_LOOKUP;
                  r_write  <= req_write;
                  r_line   <= req_addr[ADDR_WIDTH-1:OFF_W];
                  r_wsel   <= (WPL > 1) ? req_addr[WB_W +: WSEL_W] : '0;
                  r_wdata  <= req_wdata;
                  refilled <= 1'b0;
               end
            end

            ST_LOOKUP: begin
               if (req_hit) begin
                  state      <= ST_RESPOND;
                  resp_valid <= 1'b1;
                  resp_rdata <= r_write ? r_wdata : hit_word;
                  // The lookup that follows a refill was already counted as a miss.
                  if (!refilled) hit_count <= sat_inc(hit_count);
                  if (r_write) meta[req_idx][req_hit_way].dirty <= 1'b1;
                  for (int w = 0; w < NUM_WAYS; w++)
                     age_mem[req_idx][w] <= ages_next[w*WAY_W +: WAY_W];
               end else begin
                  miss_count <= sat_inc(miss_count);
                  vic_way    <= victim;
                  mem_req    <= 1'b1;
                  if (vic_meta.valid && vic_meta.dirty) begin
                     state     <= ST_WRITEBACK;
                     mem_write <= 1'b1;
                     mem_addr  <= {tag_mem[req_idx][victim], req_idx, {OFF_W{1'b0}}};
                     mem_wdata <= data_mem[req_idx][victim];
                  end else begin
                     state     <= ST_REFILL;
                     mem_write <= 1'b0;
                     mem_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                  end
               end
            end

            ST_WRITEBACK: begin
               if (mem_ack) begin
                  meta[req_idx][vic_way].dirty <= 1'b0;
                  wb_count  <= sat_inc(wb_count);
                  state     <= ST_REFILL;
                  mem_write <= 1'b0;
                  mem_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}};
               end
            end

            ST_REFILL: begin
               if (mem_ack) begin
                  meta[req_idx][vic_way] <= '{valid: 1'b1, dirty: 1'b0};
                  refilled <= 1'b1;
                  mem_req  <= 1'b0;
                  state    <= ST_LOOKUP;
               end
            end

            ST_RESPOND: state <= ST_IDLE;

            ST_SNOOP_WB: begin
               if (mem_ack) begin
                  meta[snp_idx][snp_way] <= '0;
                  wb_count   <= sat_inc(wb_count);
                  mem_req    <= 1'b0;
                  mem_write  <= 1'b0;
                  snoop_done <= 1'b1;
                  snoop_hit  <= 1'b1;
                  state      <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_level_ctrl.sv
// tb/tb_cache_level_ctrl.sv - table-driven self-checking bench for cache_level_ctrl

module tb_cache_level_ctrl;
   import cache_config::*;

   logic         clk;
   logic         reset;
   logic         req_valid, req_ready, req_write;
   logic [31:0]  req_addr, req_wdata;
   logic         resp_valid;
   logic [31:0]  resp_rdata;
   logic         mem_req, mem_write, mem_ack;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         snoop_valid, snoop_done, snoop_hit;
   logic [31:0]  snoop_addr;
   logic [31:0]  hit_count, miss_count, wb_count;

   int n_checks = 0;
   int n_fail   = 0;

   cache_level_ctrl dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
      .snoop_done(snoop_done), .snoop_hit(snoop_hit),
      .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         wr;
      logic [31:0]  addr;
      logic [31:0]  wdata;
      logic         exp_rf;
      logic [127:0] rf_line;
      logic         exp_wb;
      logic [31:0]  wb_addr;
      logic [127:0] wb_line;
      logic [31:0]  exp_rdata;
      logic [31:0]  exp_hits;
      logic [31:0]  exp_misses;
      logic [31:0]  exp_wbs;
   } vec_t;

   vec_t tbl [17];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] mk_line(input logic [31:0] a);
      return {a + 32'd12, a + 32'd8, a + 32'd4, a};
   endfunction

   function automatic vec_t mkv(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic rf, input logic [127:0] rfl,
                                input logic wb, input logic [31:0] wba, input logic [127:0] wbl,
                                input logic [31:0] rd, input logic [31:0] h,
                                input logic [31:0] m, input logic [31:0] b);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rf = rf; v.rf_line = rfl;
      v.exp_wb = wb; v.wb_addr = wba; v.wb_line = wbl; v.exp_rdata = rd;
      v.exp_hits = h; v.exp_misses = m; v.exp_wbs = b;
      return v;
   endfunction

   // One upstream access; services any memory transactions it causes.
   task automatic do_access(input vec_t v, input string nm);
      bit got;
      int nrf, nwb, lat;
      @(negedge clk);
      req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
      #1 check($sformatf("%s_ready", nm), req_ready, 1'b1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      got = 0; nrf = 0; nwb = 0; lat = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            got = 1;
            lat = c;
            break;
         end
         if (mem_req) begin
            if (mem_write) begin
               nwb++;
               check($sformatf("%s_wb_addr", nm), mem_addr, v.wb_addr);
               check($sformatf("%s_wb_line", nm), mem_wdata, v.wb_line);
            end else begin
               nrf++;
               check($sformatf("%s_rf_addr", nm), mem_addr, v.addr & 32'hFFFF_FFF0);
               mem_rdata = v.rf_line;
            end
            mem_ack = 1'b1;
            @(posedge clk);
            #1 mem_ack = 1'b0;
         end
      end
      check($sformatf("%s_resp_seen", nm), got, 1'b1);
      if (got) begin
         check($sformatf("%s_rdata", nm), resp_rdata, v.exp_rdata);
         if (!v.exp_rf) check($sformatf("%s_latency", nm), lat, 2);
      end
      check($sformatf("%s_refills", nm), nrf, v.exp_rf);
      check($sformatf("%s_wbacks", nm), nwb, v.exp_wb);
      @(negedge clk);
      check($sformatf("%s_resp_1cyc", nm), resp_valid, 1'b0);
      check($sformatf("%s_hits", nm), hit_count, v.exp_hits);
      check($sformatf("%s_misses", nm), miss_count, v.exp_misses);
      check($sformatf("%s_wbcnt", nm), wb_count, v.exp_wbs);
   endtask

   // Snoop expected to complete in IDLE within one cycle.
   task automatic do_snoop(input logic [31:0] a, input logic exp_hit, input string nm);
      @(negedge clk);
      snoop_valid = 1'b1; snoop_addr = a;
      @(posedge clk);
      #1 snoop_valid = 1'b0;
      @(negedge clk);
      check($sformatf("%s_done", nm), snoop_done, 1'b1);
      check($sformatf("%s_hit", nm), snoop_hit, exp_hit);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   logic [127:0] l40, l40w, l200w;
   bit           got, early, saw_resp;
   int           lat;

   initial begin
      l40   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
      l40w  = {32'h3333_3333, 32'h2222_2222, 32'h0000_1234, 32'hDEAD_BEEF};
      l200w = {32'h0000_020C, 32'h0000_0208, 32'h0000_A5A5, 32'h0000_0200};
      //               wr    addr           wdata  rf  rf_line                 wb  wb_addr  wb_line rdata          h  m   b
      tbl[0]  = mkv(1'b0, 32'h40,       32'h0,    1, l40,                    0, 32'h0,  '0,   32'hDEADBEEF,  0, 1,  0);
      tbl[1]  = mkv(1'b0, 32'h40,       32'h0,    0, '0,                     0, 32'h0,  '0,   32'hDEADBEEF,  1, 1,  0);
      tbl[2]  = mkv(1'b1, 32'h44,       32'h1234, 0, '0,                     0, 32'h0,  '0,   32'h1234,      2, 1,  0);
      tbl[3]  = mkv(1'b0, 32'h80,       32'h0,    1, mk_line(32'h80),        0, 32'h0,  '0,   32'h80,        2, 2,  0);
      tbl[4]  = mkv(1'b0, 32'hC8,       32'h0,    1, mk_line(32'hC0),        0, 32'h0,  '0,   32'hC8,        2, 3,  0);
      tbl[5]  = mkv(1'b0, 32'h10C,      32'h0,    1, mk_line(32'h100),       0, 32'h0,  '0,   32'h10C,       2, 4,  0);
      tbl[6]  = mkv(1'b0, 32'h44,       32'h0,    0, '0,                     0, 32'h0,  '0,   32'h1234,      3, 4,  0);
      tbl[7]  = mkv(1'b0, 32'h140,      32'h0,    1, mk_line(32'h140),       0, 32'h0,  '0,   32'h140,       3, 5,  0);
      tbl[8]  = mkv(1'b0, 32'h180,      32'h0,    1, mk_line(32'h180),       0, 32'h0,  '0,   32'h180,       3, 6,  0);
      tbl[9]  = mkv(1'b0, 32'h1C0,      32'h0,    1, mk_line(32'h1C0),       0, 32'h0,  '0,   32'h1C0,       3, 7,  0);
      tbl[10] = mkv(1'b0, 32'h200,      32'h0,    1, mk_line(32'h200),       1, 32'h40, l40w, 32'h200,       3, 8,  1);
      tbl[11] = mkv(1'b0, 32'h140,      32'h0,    0, '0,                     0, 32'h0,  '0,   32'h140,       4, 8,  1);
      tbl[12] = mkv(1'b0, 32'h50,       32'h0,    1, mk_line(32'h50),        0, 32'h0,  '0,   32'h50,        4, 9,  1);
      tbl[13] = mkv(1'b1, 32'h68,       32'hBEEF, 1, mk_line(32'h60),        0, 32'h0,  '0,   32'hBEEF,      4, 10, 1);
      tbl[14] = mkv(1'b0, 32'h68,       32'h0,    0, '0,                     0, 32'h0,  '0,   32'hBEEF,      5, 10, 1);
      tbl[15] = mkv(1'b0, 32'hFFFFFFFC, 32'h0,    1, mk_line(32'hFFFFFFF0),  0, 32'h0,  '0,   32'hFFFFFFFC,  5, 11, 1);
      tbl[16] = mkv(1'b1, 32'h204,      32'hA5A5, 0, '0,                     0, 32'h0,  '0,   32'hA5A5,      6, 11, 1);

      reset = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0; snoop_valid = 1'b0; snoop_addr = '0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_snoop_done", snoop_done, 1'b0);
      check("rst_counters", {hit_count, miss_count, wb_count}, 96'h0);
      reset = 1'b0;

      for (int i = 0; i < 17; i++) do_access(tbl[i], $sformatf("v%0d", i));

      // Dirty snoop races a pending request: the snoop wins and writes back first.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1C0;
      snoop_valid = 1'b1; snoop_addr = 32'h200;
      #1 check("dsnp_ready_blocked", req_ready, 1'b0);
      @(posedge clk);
      #1 snoop_valid = 1'b0;
      got = 0; early = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (resp_valid) early = 1;
         if (mem_req) begin
            check("dsnp_mem_write", mem_write, 1'b1);
            check("dsnp_mem_addr", mem_addr, 32'h200);
            check("dsnp_mem_wdata", mem_wdata, l200w);
            check("dsnp_ready_busy", req_ready, 1'b0);
            mem_ack = 1'b1;
            @(posedge clk);
            #1 mem_ack = 1'b0;
            got = 1;
            break;
         end
      end
      check("dsnp_wb_seen", got, 1'b1);
      @(negedge clk);
      check("dsnp_done", snoop_done, 1'b1);
      check("dsnp_hit", snoop_hit, 1'b1);
      check("dsnp_no_early_resp", early, 1'b0);
      check("dsnp_ready_after", req_ready, 1'b1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      got = 0; lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (resp_valid) begin got = 1; lat = c; break; end
      end
      check("dsnp_req_resp", got, 1'b1);
      check("dsnp_req_rdata", resp_rdata, 32'h1C0);
      check("dsnp_req_latency", lat, 2);
      check("dsnp_wbcnt", wb_count, 32'd2);
      check("dsnp_hits", hit_count, 32'd7);

      do_snoop(32'h200, 1'b0, "snp_gone");
      do_snoop(32'h1C0, 1'b1, "snp_clean");
      do_access(mkv(1'b0, 32'h1C0, 32'h0, 1, mk_line(32'h1C0), 0, 32'h0, '0, 32'h1C0, 7, 12, 2), "snp_refetch");

      // Stray mem_ack while idle must do nothing.
      @(negedge clk);
      mem_ack = 1'b1;
      @(posedge clk);
      #1 mem_ack = 1'b0;
      @(negedge clk);
      check("stray_ack_mem_req", mem_req, 1'b0);
      check("stray_ack_counts", {hit_count, miss_count, wb_count}, {32'd7, 32'd12, 32'd2});
      check("stray_ack_ready", req_ready, 1'b1);

      // Reset during REFILL abandons the miss.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h240;
      @(posedge clk);
      #1 req_valid = 1'b0;
      got = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mem_req) begin got = 1; break; end
      end
      check("rrf_refill_seen", got, 1'b1);
      check("rrf_mem_write", mem_write, 1'b0);
      check("rrf_mem_addr", mem_addr, 32'h240);
      #1 reset = 1'b1;
      #1 check("rrf_mem_req_drop", mem_req, 1'b0);
      check("rrf_ready", req_ready, 1'b1);
      saw_resp = 0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid) saw_resp = 1;
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid || mem_req) saw_resp = 1;
      end
      check("rrf_no_resp", saw_resp, 1'b0);
      check("rrf_counters", {hit_count, miss_count, wb_count}, 96'h0);
      do_snoop(32'h240, 1'b0, "rrf_snoop");
      do_access(mkv(1'b0, 32'h248, 32'h0, 1, mk_line(32'h240), 0, 32'h0, '0, 32'h248, 0, 1, 0), "rrf_retry");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
